// File: rtl/sum_range_decoder_pkg.sv
// Shared types and widths for the sum range decoder.
//   state_t : decoder FSM states
//   VAL_W   : width of range values (start/stop/i)
//   SUM_W   : width of the target sum and the running remainder
//   VAL_MAX : largest representable range value
package sum_range_decoder_pkg;

  localparam int unsigned VAL_W   = 8;
  localparam int unsigned SUM_W   = 17;
  localparam int unsigned VAL_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_range_decoder.sv
// Sum range decoder: given a first value 'start' and a target 'sum', finds the
// last value 'stop' such that start+...+stop reaches the target, one compare
// per clock.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   req   : request, sampled only while busy=0
//   start : first value of the range
//   sum   : target sum
//   busy  : decode in progress (from request acceptance through the done cycle)
//   done  : one-cycle pulse when stop/exact/err become valid
//   stop  : decoded last value of the range
//   exact : range sums exactly to the target
//   err   : empty range (sum < start) or range overflow past VAL_MAX
module sum_range_decoder
  import sum_range_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [VAL_W-1:0] start,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [VAL_W-1:0] stop,
  output logic             exact,
  output logic             err
);

  state_t           state;
  logic [SUM_W-1:0] rem;
  logic [VAL_W-1:0] i;
  logic             first;
  logic [SUM_W-1:0] i_ext;

  // Current range value widened to the remainder width for compare/subtract.
  always_comb begin
    i_ext = SUM_W'(i);
  end

  // FSM and datapath. The cycle after a request is accepted is spent in IDLE
  // with busy=1 (operands latched) before the first compare in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      stop  <= '0;
      exact <= 1'b0;
      err   <= 1'b0;
      rem   <= '0;
      i     <= '0;
      first <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (busy) begin
            state <= RUN;
          end else if (req) begin
            rem   <= sum;
            i     <= start;
            first <= 1'b1;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (rem == i_ext) begin
            stop  <= i;
            exact <= 1'b1;
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rem < i_ext) begin
            // On the first compare i still equals start: the range is empty.
            stop  <= first ? i : i - VAL_W'(1);
            exact <= 1'b0;
            err   <= first;
            done  <= 1'b1;
            state <= DONE;
          end else if (i == VAL_W'(VAL_MAX)) begin
            stop  <= i;
            exact <= 1'b0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rem   <= rem - i_ext;
            i     <= i + VAL_W'(1);
            first <= 1'b0;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
